// File: rtl/vga_pkg.sv
// Shared VGA timing constants, button indices and motion-controller types.
// Also holds the direction-resolve and per-axis clamp helpers.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int TICK_LINE = 481;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_MOVE_X,
        ST_MOVE_Y,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    // Opposing buttons pressed together cancel out on that axis.
    function automatic dir_t resolve_dir(input logic [3:0] btn);
        dir_t d;
        d.up    = btn[BTN_UP]    & ~btn[BTN_DOWN];
        d.down  = btn[BTN_DOWN]  & ~btn[BTN_UP];
        d.left  = btn[BTN_LEFT]  & ~btn[BTN_RIGHT];
        d.right = btn[BTN_RIGHT] & ~btn[BTN_LEFT];
        return d;
    endfunction

    // One axis step, clamped to [0, limit]; the sum is 11 bits so it cannot wrap.
    function automatic logic [9:0] move_axis(input logic [9:0]  pos,
                                             input logic [10:0] step,
                                             input logic [9:0]  limit,
                                             input logic        inc,
                                             input logic        dec);
        logic [10:0] sum;
        sum = {1'b0, pos} + step;
        if (inc)
            return (sum > {1'b0, limit}) ? limit : sum[9:0];
        else if (dec)
            return ({1'b0, pos} < step) ? 10'd0 : pos - step[9:0];
        else
            return pos;
    endfunction

endpackage

// File: rtl/object_motion_ctrl_if.sv
// Button/scan-line inputs and object position outputs of the motion controller.
// The controller takes the slave side; the environment takes the master side.
interface object_motion_ctrl_if;

    logic [3:0] push;
    logic [9:0] pixel_y;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic       frame_tick;
    logic       update_done;
    logic       fast;

    modport slave (
        input  push, pixel_y,
        output obj_x, obj_y, frame_tick, update_done, fast
    );

    modport master (
        output push, pixel_y,
        input  obj_x, obj_y, frame_tick, update_done, fast
    );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous push buttons, async active-low reset.
module btn_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking so both stages shift on the same edge; blocking would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/object_motion_ctrl.sv
// Per-frame object motion controller: samples buttons once per frame during
// vertical blanking and commits a clamped, optionally accelerated position.
module object_motion_ctrl #(
    parameter int H_DISPLAY    = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY    = vga_pkg::V_DISPLAY,
    parameter int OBJ_SIZE     = 16,
    parameter int STEP         = 2,
    parameter int ACCEL_FRAMES = 32,
    parameter int X_INIT       = 312,
    parameter int Y_INIT       = 232,
    parameter int TICK_LINE    = vga_pkg::TICK_LINE
) (
    input  logic                 clk,
    input  logic                 rst,
    object_motion_ctrl_if.slave  bus
);

    import vga_pkg::*;

    localparam logic [9:0]  X_LIMIT   = 10'(H_DISPLAY - OBJ_SIZE);
    localparam logic [9:0]  Y_LIMIT   = 10'(V_DISPLAY - OBJ_SIZE);
    localparam logic [10:0] STEP_SLOW = 11'(STEP);
    localparam logic [10:0] STEP_FAST = 11'(2 * STEP);
    localparam logic [5:0]  HOLD_MAX  = 6'(ACCEL_FRAMES);
    localparam logic [9:0]  TICK_Y    = 10'(TICK_LINE);

    logic [3:0]  btn_s;
    logic        line_hit;
    logic        line_hit_q;
    logic        frame_tick_q;
    state_t      state_q;
    dir_t        dir_q;
    dir_t        dir_d;
    logic [5:0]  hold_q;
    logic [5:0]  hold_d;
    logic        fast_q;
    logic        update_done_q;
    logic [9:0]  obj_x_q;
    logic [9:0]  obj_y_q;
    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic [10:0] step;

    btn_sync #(.WIDTH(4)) u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.push),
        .sync_o  (btn_s)
    );

    // pixel_y sits on the tick line for many clocks; only its first cycle ticks.
    assign line_hit = (bus.pixel_y == TICK_Y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_hit_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            line_hit_q   <= line_hit;
            frame_tick_q <= line_hit & ~line_hit_q;
        end
    end

    // NOTE: every output of this block gets a value on every path, so no latch can be inferred.
    always_comb begin
        dir_d  = resolve_dir(btn_s);
        hold_d = '0;
        if (dir_d != '0)
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 6'd1;
        step = fast_q ? STEP_FAST : STEP_SLOW;
        x_d  = move_axis(obj_x_q, step, X_LIMIT, dir_q.right, dir_q.left);
        y_d  = move_axis(obj_y_q, step, Y_LIMIT, dir_q.down,  dir_q.up);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            dir_q         <= '0;
            hold_q        <= '0;
            fast_q        <= 1'b0;
            update_done_q <= 1'b0;
            obj_x_q       <= 10'(X_INIT);
            obj_y_q       <= 10'(Y_INIT);
        end else begin
            update_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick_q)
                        state_q <= ST_SAMPLE;
                end
                // fast is refreshed here so the saturating frame already moves at the fast step
                ST_SAMPLE: begin
                    dir_q   <= dir_d;
                    hold_q  <= hold_d;
                    fast_q  <= (hold_d == HOLD_MAX);
                    state_q <= ST_MOVE_X;
                end
                ST_MOVE_X: begin
                    obj_x_q <= x_d;
                    state_q <= ST_MOVE_Y;
                end
                ST_MOVE_Y: begin
                    obj_y_q       <= y_d;
                    update_done_q <= 1'b1;
                    state_q       <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.obj_x       = obj_x_q;
    assign bus.obj_y       = obj_y_q;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.update_done = update_done_q;
    assign bus.fast        = fast_q;

endmodule

// File: doc/object_motion_ctrl.md
# object_motion_ctrl

Per-frame motion controller for the on-screen animated object. Samples the four push buttons once per video frame, during vertical blanking, and computes a new clamped object position. Sits between the push-button inputs and the pixel generator, which draws the object at `obj_x`/`obj_y`. Watches `pixel_y` from the VGA sync block to find the frame boundary, so the position never changes while a frame is being drawn.

## Interface
Parameters:
- `H_DISPLAY`, 640: visible width in pixels.
- `V_DISPLAY`, 480: visible height in pixels.
- `OBJ_SIZE`, 16: object edge length in pixels (square).
- `STEP`, 2: base move per frame, in pixels.
- `ACCEL_FRAMES`, 32: number of consecutive held frames before the step doubles.
- `X_INIT`, 312: reset x position.
- `Y_INIT`, 232: reset y position.
- `TICK_LINE`, 481: scan line that marks the frame boundary.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `push` in 4: raw buttons. [0]=up, [1]=down, [2]=left, [3]=right. Asynchronous, active-high.
- `pixel_y` in 10: current scan line from the sync block.
- `obj_x` out 10: object top-left x.
- `obj_y` out 10: object top-left y.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.
- `update_done` out 1: one-cycle pulse when the new position is committed.
- `fast` out 1: high while the accelerated step is active.

## Operation
- **Button synchronisation:** `push` passes through a 2-flop synchroniser.
- **Frame tick:** `frame_tick` = rising edge of (`pixel_y == TICK_LINE`), registered. It fires exactly once per frame, even though `pixel_y` holds for many `clk` cycles.
- **FSM states:** IDLE, SAMPLE, MOVE_X, MOVE_Y, DONE.
  - IDLE → SAMPLE on `frame_tick`.
  - SAMPLE: latch the synchronised buttons and resolve direction.
    - up and down both set → no vertical motion.
    - left and right both set → no horizontal motion.
    - Update the hold counter (see Acceleration).
  - MOVE_X → MOVE_Y → DONE → IDLE, unconditionally.
- **Step:** step = `fast` ? 2·`STEP` : `STEP`.
- **MOVE_X:**
  - right: `obj_x` ← min(`obj_x`+step, `H_DISPLAY`−`OBJ_SIZE`).
  - left: `obj_x` ← (`obj_x` < step) ? 0 : `obj_x`−step.
- **MOVE_Y:** same rules with up/down, limit `V_DISPLAY`−`OBJ_SIZE`.
- **Arithmetic:** 11-bit internally so the sum cannot overflow before the clamp. Outputs are 10-bit.
- **Acceleration:**
  - Hold counter (6-bit) increments in SAMPLE when any direction resolves as active, saturating at `ACCEL_FRAMES`.
  - It clears to 0 in SAMPLE when no direction is active.
  - `fast` = (counter == `ACCEL_FRAMES`).
- **`update_done`:** asserted during DONE.
- **Reset** (asynchronous, `rst`=0):
  - `obj_x`=`X_INIT`, `obj_y`=`Y_INIT`.
  - State IDLE, hold counter 0, synchroniser flops 0.
  - `frame_tick`=0, `update_done`=0, `fast`=0.
- **Boundary and corner cases:**
  - `frame_tick` outside IDLE is ignored. This cannot occur with a legal frame length.
  - An object at a wall with the button held stays at the wall, and the counter still advances.
  - Reset mid-sequence aborts the update; the position returns to its init values.
  - Release on the same frame that would reach `ACCEL_FRAMES`: counter clears, `fast` stays 0.

## Timing
- Cycle t: `frame_tick`=1.
- t+1: SAMPLE.
- t+2: MOVE_X. `obj_x` takes its new value at the end of this cycle.
- t+3: MOVE_Y. `obj_y` takes its new value at the end of this cycle.
- t+4: DONE, `update_done`=1.
- Total latency: 4 cycles from `frame_tick` to `update_done`. Well inside vertical blanking.
- Button-to-sample latency: 2 cycles of synchroniser, plus the wait until the next frame tick.
- `obj_x`/`obj_y` are stable during every active-video line.

## Structure
- Shared package `vga_pkg`: `H_DISPLAY`, `V_DISPLAY`, `TICK_LINE` (the same constants the sync block uses), button index constants, FSM state encoding.
- One sub-module: `btn_sync`, a 4-bit 2-flop synchroniser with async active-low reset. Reused by other button-driven blocks.

## Test plan
- **Reset:** release reset, run 2 frames with no buttons → `obj_x`=312, `obj_y`=232. `update_done` pulses once per frame.
- **Basic move:** hold right for 5 frames → `obj_x`=322, `obj_y` unchanged. Each `obj_x` change occurs only while `pixel_y` ≥ 481.
- **Wall clamp:** hold left from `obj_x`=3 → frame 1 gives 1, frame 2 gives 0, frame 3 stays 0. Hold down from 462 → 464 and stays (480−16).
- **Conflicting buttons:** hold up+down+right for 3 frames → `obj_y` unchanged, `obj_x` +6.
- **Acceleration:**
  - Hold right 40 frames from 312 → `fast` rises after frame 32, steps become 4.
  - Final `obj_x` = 312 + 31·2 + 9·4 = 410. (The SAMPLE that saturates the counter precedes the move in the same update, so frame 32 already uses step 4.)
  - Release for one frame → `fast`=0.
- **Async reset mid-update:** assert `rst` low during MOVE_X → outputs return to 312/232 immediately. After release, the next frame updates normally.
